// File: rtl/id_stage.sv
// id_stage: registered RV32I decode stage with valid/ready handshakes, EX/MEM operand forwarding,
// load-use stall and flush. Define ID_MEM_FWD_EN to enable forwarding from the MEM stage.
module id_stage #(
    parameter  int XLEN        = 32,
    parameter  int REGW        = 5,
    localparam int RTLOP_BUS   = 5,
    localparam int RTLTYPE_BUS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            instr_i,
    input  logic [XLEN-1:0]        pc_i,
    output logic [REGW-1:0]        gprs_raddr1,
    output logic [REGW-1:0]        gprs_raddr2,
    input  logic [XLEN-1:0]        gprs_rdata1_i,
    input  logic [XLEN-1:0]        gprs_rdata2_i,
    input  logic [REGW-1:0]        ex_gprs_waddr,
    input  logic [XLEN-1:0]        ex_gprs_wdata,
    input  logic                   ex_is_load,
    input  logic [REGW-1:0]        mem_gprs_waddr,
    input  logic [XLEN-1:0]        mem_gprs_wdata,
    input  logic                   flush_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RTLOP_BUS-1:0]   rtlop_o,
    output logic [RTLTYPE_BUS-1:0] rtltype_o,
    output logic [XLEN-1:0]        pc_o,
    output logic [XLEN-1:0]        src1_o,
    output logic [XLEN-1:0]        src2_o,
    output logic [XLEN-1:0]        store_data_o,
    output logic [XLEN-1:0]        target_o,
    output logic [2:0]             mem_size_o,
    output logic [REGW-1:0]        gprs_waddr_o,
    output logic                   error_o
);

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU ops are {2'b00, funct3}; branches are {2'b01, funct3}; SRA gets its own code.
    localparam logic [RTLOP_BUS-1:0] OP_ADD = 5'b00000;
    localparam logic [RTLOP_BUS-1:0] OP_SRA = 5'b10101;

    typedef enum logic [RTLTYPE_BUS-1:0] {
        ARICH  = 3'd0,
        RMEM   = 3'd1,
        WMEM   = 3'd2,
        JUMP   = 3'd3,
        BRANCH = 3'd4
    } rtltype_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] immI;
    logic [XLEN-1:0] immS;
    logic [XLEN-1:0] immB;
    logic [XLEN-1:0] immJ;
    logic [XLEN-1:0] immU;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rs1    = REGW'(instr_i[19:15]);
    assign rs2    = REGW'(instr_i[24:20]);
    assign rd     = REGW'(instr_i[11:7]);

    assign gprs_raddr1 = rs1;
    assign gprs_raddr2 = rs2;

    assign immI = sext32({{20{instr_i[31]}}, instr_i[31:20]});
    assign immS = sext32({{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]});
    assign immB = sext32({{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                          instr_i[11:8], 1'b0});
    assign immJ = sext32({{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                          instr_i[30:21], 1'b0});
    assign immU = sext32({instr_i[31:12], 12'b0});

    // EX is checked last so that it overrides a MEM match on the same register.
    always_comb begin
        rs1Data = gprs_rdata1_i;
        rs2Data = gprs_rdata2_i;
`ifdef ID_MEM_FWD_EN
        if (rs1 != '0 && rs1 == mem_gprs_waddr) rs1Data = mem_gprs_wdata;
        if (rs2 != '0 && rs2 == mem_gprs_waddr) rs2Data = mem_gprs_wdata;
`endif
        if (rs1 != '0 && rs1 == ex_gprs_waddr) rs1Data = ex_gprs_wdata;
        if (rs2 != '0 && rs2 == ex_gprs_waddr) rs2Data = ex_gprs_wdata;
    end

`ifdef ID_MEM_FWD_EN
`else
    logic unusedMemFwd;
    assign unusedMemFwd = ^{mem_gprs_waddr, mem_gprs_wdata};
`endif

    logic [RTLOP_BUS-1:0] rtlop_d;
    rtltype_e             rtltype_d;
    logic [XLEN-1:0]      src1_d;
    logic [XLEN-1:0]      src2_d;
    logic [XLEN-1:0]      store_data_d;
    logic [XLEN-1:0]      target_d;
    logic [2:0]           mem_size_d;
    logic [REGW-1:0]      gprs_waddr_d;
    logic                 error_d;
    logic                 useRs1;
    logic                 useRs2;

    always_comb begin
        rtlop_d      = OP_ADD;
        rtltype_d    = ARICH;
        src1_d       = rs1Data;
        src2_d       = '0;
        store_data_d = '0;
        target_d     = '0;
        mem_size_d   = '0;
        gprs_waddr_d = rd;
        error_d      = 1'b0;
        useRs1       = 1'b0;
        useRs2       = 1'b0;
        case (opcode)
            OPC_OPIMM: begin
                useRs1  = 1'b1;
                src2_d  = immI;
                rtlop_d = {2'b00, funct3};
                if (funct3 == 3'b001 && funct7 != 7'h00) error_d = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == 7'h20)      rtlop_d = OP_SRA;
                    else if (funct7 != 7'h00) error_d = 1'b1;
                end
            end
            OPC_OP: begin
                useRs1  = 1'b1;
                useRs2  = 1'b1;
                src2_d  = rs2Data;
                rtlop_d = {2'b00, funct3};
                // SUB is executed as an ADD of the negated operand.
                if (funct7[5]) begin
                    if (funct3 == 3'b000)      src2_d  = '0 - rs2Data;
                    else if (funct3 == 3'b101) rtlop_d = OP_SRA;
                end
            end
            OPC_LOAD: begin
                useRs1     = 1'b1;
                rtltype_d  = RMEM;
                src2_d     = immI;
                mem_size_d = funct3;
                error_d    = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                useRs1       = 1'b1;
                useRs2       = 1'b1;
                rtltype_d    = WMEM;
                src2_d       = immS;
                store_data_d = rs2Data;
                mem_size_d   = funct3;
                gprs_waddr_d = '0;
                error_d      = funct3 > 3'd2;
            end
            OPC_BRANCH: begin
                useRs1       = 1'b1;
                useRs2       = 1'b1;
                rtltype_d    = BRANCH;
                rtlop_d      = {2'b01, funct3};
                src2_d       = rs2Data;
                store_data_d = rs2Data;
                target_d     = pc_i + immB;
                gprs_waddr_d = '0;
                error_d      = funct3[2:1] == 2'b01;
            end
            OPC_JAL: begin
                rtltype_d = JUMP;
                src1_d    = pc_i;
                src2_d    = immJ;
                target_d  = pc_i + immJ;
            end
            OPC_JALR: begin
                useRs1    = 1'b1;
                rtltype_d = JUMP;
                src2_d    = immI;
            end
            OPC_LUI: begin
                src1_d = immU;
            end
            OPC_AUIPC: begin
                src1_d = pc_i;
                src2_d = immU;
            end
            default: begin
                src1_d  = '0;
                error_d = 1'b1;
            end
        endcase
        if (error_d) gprs_waddr_d = '0;
    end

    logic hazard;
    logic canAdvance;
    logic accept;

    // A load in EX has no data yet, so any instruction reading its destination must wait.
    assign hazard = ex_is_load && (ex_gprs_waddr != '0) &&
                    ((useRs1 && rs1 == ex_gprs_waddr) || (useRs2 && rs2 == ex_gprs_waddr));

    logic                 out_valid_q;
    logic [RTLOP_BUS-1:0] rtlop_q;
    rtltype_e             rtltype_q;
    logic [XLEN-1:0]      pc_q;
    logic [XLEN-1:0]      src1_q;
    logic [XLEN-1:0]      src2_q;
    logic [XLEN-1:0]      store_data_q;
    logic [XLEN-1:0]      target_q;
    logic [2:0]           mem_size_q;
    logic [REGW-1:0]      gprs_waddr_q;
    logic                 error_q;

    assign canAdvance = ~out_valid_q | out_ready;
    assign in_ready   = canAdvance & ~hazard;
    assign accept     = in_valid & in_ready;

    // When the output drains without a new acceptance (idle or stalled), a bubble is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            rtlop_q      <= OP_ADD;
            rtltype_q    <= ARICH;
            pc_q         <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            store_data_q <= '0;
            target_q     <= '0;
            mem_size_q   <= '0;
            gprs_waddr_q <= '0;
            error_q      <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            rtlop_q      <= rtlop_d;
            rtltype_q    <= rtltype_d;
            pc_q         <= pc_i;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            store_data_q <= store_data_d;
            target_q     <= target_d;
            mem_size_q   <= mem_size_d;
            gprs_waddr_q <= gprs_waddr_d;
            error_q      <= error_d;
        end else if (canAdvance) begin
            out_valid_q  <= 1'b0;
            gprs_waddr_q <= '0;
        end
    end

    assign out_valid    = out_valid_q;
    assign rtlop_o      = rtlop_q;
    assign rtltype_o    = rtltype_q;
    assign pc_o         = pc_q;
    assign src1_o       = src1_q;
    assign src2_o       = src2_q;
    assign store_data_o = store_data_q;
    assign target_o     = target_q;
    assign mem_size_o   = mem_size_q;
    assign gprs_waddr_o = gprs_waddr_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed handshake/hazard/flush/reset scenarios for id_stage followed by a
// randomized decode sweep checked against an arithmetic model of the RV32I rules.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [4:0]  gprs_raddr1;
    logic [4:0]  gprs_raddr2;
    logic [31:0] gprs_rdata1_i;
    logic [31:0] gprs_rdata2_i;
    logic [4:0]  ex_gprs_waddr;
    logic [31:0] ex_gprs_wdata;
    logic        ex_is_load;
    logic [4:0]  mem_gprs_waddr;
    logic [31:0] mem_gprs_wdata;
    logic        flush_i;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  rtlop_o;
    logic [2:0]  rtltype_o;
    logic [31:0] pc_o;
    logic [31:0] src1_o;
    logic [31:0] src2_o;
    logic [31:0] store_data_o;
    logic [31:0] target_o;
    logic [2:0]  mem_size_o;
    logic [4:0]  gprs_waddr_o;
    logic        error_o;

    logic [31:0] rf [32];

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  typ;
        logic [31:0] pc;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] sd;
        logic [31:0] tgt;
        logic [2:0]  sz;
        logic [4:0]  wa;
        logic        err;
    } exp_t;

    id_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instr_i        (instr_i),
        .pc_i           (pc_i),
        .gprs_raddr1    (gprs_raddr1),
        .gprs_raddr2    (gprs_raddr2),
        .gprs_rdata1_i  (gprs_rdata1_i),
        .gprs_rdata2_i  (gprs_rdata2_i),
        .ex_gprs_waddr  (ex_gprs_waddr),
        .ex_gprs_wdata  (ex_gprs_wdata),
        .ex_is_load     (ex_is_load),
        .mem_gprs_waddr (mem_gprs_waddr),
        .mem_gprs_wdata (mem_gprs_wdata),
        .flush_i        (flush_i),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .rtlop_o        (rtlop_o),
        .rtltype_o      (rtltype_o),
        .pc_o           (pc_o),
        .src1_o         (src1_o),
        .src2_o         (src2_o),
        .store_data_o   (store_data_o),
        .target_o       (target_o),
        .mem_size_o     (mem_size_o),
        .gprs_waddr_o   (gprs_waddr_o),
        .error_o        (error_o)
    );

    always #5 clk = ~clk;

    assign gprs_rdata1_i = rf[gprs_raddr1];
    assign gprs_rdata2_i = rf[gprs_raddr2];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] fwdModel(input logic [4:0] rs, input logic [4:0] exA,
                                             input logic [31:0] exD, input logic [4:0] memA,
                                             input logic [31:0] memD);
        bit memFwd;
`ifdef ID_MEM_FWD_EN
        memFwd = 1'b1;
`else
        memFwd = 1'b0;
`endif
        if (rs == 5'd0) return rf[0];
        if (rs == exA) return exD;
        if (memFwd && rs == memA) return memD;
        return rf[rs];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [4:0] exA, input logic [31:0] exD,
                                   input logic [4:0] memA, input logic [31:0] memD);
        exp_t        e;
        int          f3;
        int          f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] iImm;
        logic [31:0] sImm;
        logic [31:0] bImm;
        logic [31:0] jImm;
        logic [31:0] uImm;
        f3   = int'(ins[14:12]);
        f7   = int'(ins[31:25]);
        a    = fwdModel(ins[19:15], exA, exD, memA, memD);
        b    = fwdModel(ins[24:20], exA, exD, memA, memD);
        iImm = 32'(ins[31:20]) - (ins[31] ? 32'd4096 : 32'd0);
        sImm = 32'(ins[31:25]) * 32 + 32'(ins[11:7]) - (ins[31] ? 32'd4096 : 32'd0);
        bImm = 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2
               - (ins[31] ? 32'd4096 : 32'd0);
        jImm = 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2
               - (ins[31] ? 32'h100000 : 32'd0);
        uImm = ins & 32'hFFFFF000;
        e.op = 5'd0; e.typ = 3'd0; e.pc = pc; e.s1 = a; e.s2 = 32'd0; e.sd = 32'd0;
        e.tgt = 32'd0; e.sz = 3'd0; e.wa = ins[11:7]; e.err = 1'b0;
        case (ins[6:0])
            7'h13: begin
                e.s2 = iImm;
                e.op = 5'(f3);
                if (f3 == 1 && f7 != 0) e.err = 1'b1;
                if (f3 == 5) begin
                    if (f7 == 32)     e.op = 5'd21;
                    else if (f7 != 0) e.err = 1'b1;
                end
            end
            7'h33: begin
                e.s2 = (f3 == 0 && ins[30]) ? 32'd0 - b : b;
                e.op = (f3 == 5 && ins[30]) ? 5'd21 : 5'(f3);
            end
            7'h03: begin
                e.typ = 3'd1; e.s2 = iImm; e.sz = 3'(f3);
                e.err = (f3 == 3 || f3 == 6 || f3 == 7);
            end
            7'h23: begin
                e.typ = 3'd2; e.s2 = sImm; e.sd = b; e.sz = 3'(f3); e.wa = 5'd0;
                e.err = f3 > 2;
            end
            7'h63: begin
                e.typ = 3'd4; e.op = 5'(8 + f3); e.s2 = b; e.sd = b; e.tgt = pc + bImm;
                e.wa = 5'd0; e.err = (f3 == 2 || f3 == 3);
            end
            7'h6F: begin
                e.typ = 3'd3; e.s1 = pc; e.s2 = jImm; e.tgt = pc + jImm;
            end
            7'h67: begin
                e.typ = 3'd3; e.s2 = iImm;
            end
            7'h37: begin
                e.s1 = uImm;
            end
            7'h17: begin
                e.s1 = pc; e.s2 = uImm;
            end
            default: e.err = 1'b1;
        endcase
        if (e.err) e.wa = 5'd0;
        return e;
    endfunction

    task automatic checkDecode(input string tag, input exp_t e);
        checkOutput({tag, ".valid"}, out_valid, 1);
        checkOutput({tag, ".error"}, error_o, e.err);
        checkOutput({tag, ".waddr"}, gprs_waddr_o, e.wa);
        if (!e.err) begin
            checkOutput({tag, ".rtlop"}, rtlop_o, e.op);
            checkOutput({tag, ".rtltype"}, rtltype_o, e.typ);
            checkOutput({tag, ".pc"}, pc_o, e.pc);
            checkOutput({tag, ".src1"}, src1_o, e.s1);
            checkOutput({tag, ".src2"}, src2_o, e.s2);
            checkOutput({tag, ".store_data"}, store_data_o, e.sd);
            checkOutput({tag, ".target"}, target_o, e.tgt);
            checkOutput({tag, ".mem_size"}, mem_size_o, e.sz);
        end
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] expMem;
        logic [4:0]  exA;
        logic [4:0]  memA;
        logic [31:0] exD;
        logic [31:0] memD;
        exp_t        e;
        int          sel;

        for (int k = 0; k < 32; k++) rf[k] = 32'd0;
        rst_n = 1'b0; in_valid = 1'b0; instr_i = 32'd0; pc_i = 32'd0;
        ex_gprs_waddr = 5'd0; ex_gprs_wdata = 32'd0; ex_is_load = 1'b0;
        mem_gprs_waddr = 5'd0; mem_gprs_wdata = 32'd0; flush_i = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("reset.out_valid", out_valid, 0);
        checkOutput("reset.in_ready", in_ready, 1);
        checkOutput("reset.rtlop", rtlop_o, 0);
        checkOutput("reset.rtltype", rtltype_o, 0);
        checkOutput("reset.pc", pc_o, 0);
        checkOutput("reset.src1", src1_o, 0);
        checkOutput("reset.src2", src2_o, 0);
        checkOutput("reset.store_data", store_data_o, 0);
        checkOutput("reset.target", target_o, 0);
        checkOutput("reset.mem_size", mem_size_o, 0);
        checkOutput("reset.waddr", gprs_waddr_o, 0);
        checkOutput("reset.error", error_o, 0);

        // addi x1,x0,5
        rf[1] = 32'd7; rf[2] = 32'd2;
        in_valid = 1'b1; instr_i = 32'h00500093; pc_i = 32'h100;
        tick();
        checkOutput("addi.valid", out_valid, 1);
        checkOutput("addi.src1", src1_o, 0);
        checkOutput("addi.src2", src2_o, 5);
        checkOutput("addi.waddr", gprs_waddr_o, 1);
        checkOutput("addi.rtlop", rtlop_o, 0);
        checkOutput("addi.error", error_o, 0);
        checkOutput("addi.pc", pc_o, 32'h100);

        // sub x3,x1,x2 with rs2 forwarded from EX
        instr_i = 32'h402081B3; pc_i = 32'h104; ex_gprs_waddr = 5'd2; ex_gprs_wdata = 32'd9;
        tick();
        checkOutput("sub.src1", src1_o, 7);
        checkOutput("sub.src2", src2_o, 32'hFFFFFFF7);
        checkOutput("sub.waddr", gprs_waddr_o, 3);

        // load-use: lw x5 in EX, add x6,x5,x1 in ID
        ex_is_load = 1'b1; ex_gprs_waddr = 5'd5; ex_gprs_wdata = 32'h55;
        instr_i = 32'h000283B7;
        #1;
        checkOutput("hazard.lui_no_stall", in_ready, 1);
        instr_i = 32'h00510093;
        #1;
        checkOutput("hazard.addi_rs2_unused", in_ready, 1);
        instr_i = 32'h00128333; pc_i = 32'h108;
        #1;
        checkOutput("hazard.in_ready", in_ready, 0);
        tick();
        checkOutput("hazard.bubble_valid", out_valid, 0);
        checkOutput("hazard.bubble_waddr", gprs_waddr_o, 0);
        checkOutput("hazard.still_stalled", in_ready, 0);
        tick();
        checkOutput("hazard.bubble_valid2", out_valid, 0);
        ex_is_load = 1'b0; ex_gprs_wdata = 32'h77;
        #1;
        checkOutput("hazard.released", in_ready, 1);
        tick();
        checkOutput("hazard.accept_valid", out_valid, 1);
        checkOutput("hazard.accept_waddr", gprs_waddr_o, 6);
        checkOutput("hazard.accept_src1", src1_o, 32'h77);
        checkOutput("hazard.accept_src2", src2_o, 7);

        // hold for 3 cycles; EX data changes must not be re-forwarded
        out_ready = 1'b0; instr_i = 32'h12300493; pc_i = 32'h10C; ex_gprs_wdata = 32'hDEAD;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("hold.valid", out_valid, 1);
            checkOutput("hold.waddr", gprs_waddr_o, 6);
            checkOutput("hold.src1", src1_o, 32'h77);
            checkOutput("hold.pc", pc_o, 32'h108);
            checkOutput("hold.in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("hold.release_ready", in_ready, 1);
        tick();
        checkOutput("hold.next_valid", out_valid, 1);
        checkOutput("hold.next_waddr", gprs_waddr_o, 9);
        checkOutput("hold.next_src2", src2_o, 32'h123);
        checkOutput("hold.next_pc", pc_o, 32'h10C);

        // beq x1,x2,-8 and an illegal word
        ex_gprs_waddr = 5'd0;
        instr_i = 32'hFE208CE3; pc_i = 32'h200;
        tick();
        checkOutput("beq.rtltype", rtltype_o, 4);
        checkOutput("beq.target", target_o, 32'h1F8);
        checkOutput("beq.waddr", gprs_waddr_o, 0);
        checkOutput("beq.rtlop", rtlop_o, 5'b01000);
        checkOutput("beq.src1", src1_o, 7);
        checkOutput("beq.src2", src2_o, 2);
        instr_i = 32'hFFFFFFFF; pc_i = 32'h204;
        tick();
        checkOutput("illegal.valid", out_valid, 1);
        checkOutput("illegal.error", error_o, 1);
        checkOutput("illegal.waddr", gprs_waddr_o, 0);

        // flush with a concurrent acceptance
        instr_i = 32'h00500093; pc_i = 32'h208; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; in_valid = 1'b0;
        checkOutput("flush.valid", out_valid, 0);
        tick();
        checkOutput("flush.valid_after", out_valid, 0);

        // MEM forwarding on rs1 of add x8,x9,x0, then EX priority
        rf[9] = 32'h1234;
`ifdef ID_MEM_FWD_EN
        expMem = 32'hAAAA;
`else
        expMem = 32'h1234;
`endif
        in_valid = 1'b1; instr_i = 32'h00048433; pc_i = 32'h300;
        mem_gprs_waddr = 5'd9; mem_gprs_wdata = 32'hAAAA;
        tick();
        checkOutput("memfwd.src1", src1_o, expMem);
        ex_gprs_waddr = 5'd9; ex_gprs_wdata = 32'hBBBB;
        tick();
        checkOutput("exprio.src1", src1_o, 32'hBBBB);

        // reset asserted during a hold
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset.valid", out_valid, 0);
        checkOutput("midreset.waddr", gprs_waddr_o, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        checkOutput("midreset.after_release", out_valid, 0);

        // randomized decode sweep, one instruction per cycle
        mem_gprs_waddr = 5'd0; ex_gprs_waddr = 5'd0; ex_is_load = 1'b0; in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            for (int k = 1; k < 32; k++) rf[k] = $urandom;
            ins = $urandom;
            case ($urandom_range(0, 9))
                0: begin
                    ins[6:0] = 7'h13;
                    if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                end
                1: begin
                    ins[6:0] = 7'h33;
                    ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                end
                2: ins[6:0] = 7'h03;
                3: ins[6:0] = 7'h23;
                4: ins[6:0] = 7'h63;
                5: ins[6:0] = 7'h6F;
                6: ins[6:0] = 7'h67;
                7: ins[6:0] = 7'h37;
                8: ins[6:0] = 7'h17;
                default: ;
            endcase
            pc = $urandom & 32'hFFFFFFFC;
            sel = $urandom_range(0, 2);
            exA = (sel == 0) ? ins[19:15] : (sel == 1) ? ins[24:20] : 5'($urandom);
            sel = $urandom_range(0, 2);
            memA = (sel == 0) ? ins[19:15] : (sel == 1) ? ins[24:20] : 5'($urandom);
            exD = $urandom;
            memD = $urandom;
            instr_i = ins; pc_i = pc;
            ex_gprs_waddr = exA; ex_gprs_wdata = exD;
            mem_gprs_waddr = memA; mem_gprs_wdata = memD;
            e = model(ins, pc, exA, exD, memA, memD);
            #1;
            checkOutput("rnd.in_ready", in_ready, 1);
            checkOutput("rnd.raddr1", gprs_raddr1, ins[19:15]);
            checkOutput("rnd.raddr2", gprs_raddr2, ins[24:20]);
            tick();
            checkDecode("rnd", e);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Registered, parametrised RV32I decode stage with a valid/ready handshake on both sides. It sits between the IF/ID and ID/EX boundaries and replaces the combinational decoder plus external ID_EX register. Compared with the earlier decoder it adds:
- full RV32I coverage: branches, AUIPC, load/store width;
- EX and MEM forwarding;
- load-use stall generation;
- flush.

## Interface
Parameters:
- `XLEN`, default 32: datapath width. Immediates are sign-extended to `XLEN`.
- `REGW`, default 5: register address width.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `instr_i` and `pc_i` are valid
- `in_ready`  out  1  stage accepts the input this cycle
- `instr_i`  in  32  instruction word
- `pc_i`  in  `XLEN`  instruction address
- `gprs_raddr1`, `gprs_raddr2`  out  `REGW`  combinational register-file read addresses (rs1, rs2)
- `gprs_rdata1_i`, `gprs_rdata2_i`  in  `XLEN`  asynchronous register-file read data
- `ex_gprs_waddr`  in  `REGW`  EX-stage destination register
- `ex_gprs_wdata`  in  `XLEN`  EX-stage result
- `ex_is_load`  in  1  EX instruction is a load, so its data is not yet available
- `mem_gprs_waddr`  in  `REGW`  MEM-stage destination register
- `mem_gprs_wdata`  in  `XLEN`  MEM-stage result
- `flush_i`  in  1  discard the held and the incoming instruction
- `out_valid`  out  1  registered outputs hold an instruction
- `out_ready`  in  1  EX accepts the output
- `rtlop_o`  out  `RTLOP_BUS` width  ALU operation
- `rtltype_o`  out  `RTLTYPE_BUS` width  ARICH, RMEM, WMEM, JUMP or BRANCH
- `pc_o`  out  `XLEN`  pc of the instruction
- `src1_o`, `src2_o`  out  `XLEN`  operands
- `store_data_o`  out  `XLEN`  forwarded rs2 for stores and branches
- `target_o`  out  `XLEN`  pc+B_imm for branches, pc+J_imm for JAL
- `mem_size_o`  out  3  funct3 of loads and stores
- `gprs_waddr_o`  out  `REGW`  destination register; x0 when there is no writeback
- `error_o`  out  1  illegal encoding

## Operation
Operand forwarding, per source:
- If rs equals `ex_gprs_waddr` and rs ≠ x0, use the EX data.
- Otherwise, if rs equals `mem_gprs_waddr` and rs ≠ x0, use the MEM data.
- Otherwise use the register file.
- EX has priority over MEM.

Decode:
- **OP-IMM**: src2 = I_imm. SRLI/SRAI/SLLI with a funct7 outside {0x00, 0x20 for SR; 0x00 for SLL} → error.
- **OP**: SUB gives src2 = −rs2 (two's complement, truncated to `XLEN`).
- **LOAD**: RMEM, src2 = I_imm, `mem_size_o` = funct3. funct3 ∈ {3, 6, 7} → error.
- **STORE**: WMEM, src1 = rs1, src2 = S_imm, `store_data_o` = rs2, waddr = x0. funct3 > 2 → error.
- **BRANCH**: BRANCH type, `rtlop_o` = {1'b1, funct3}, src1/src2 = rs1/rs2, waddr = x0. funct3 ∈ {2, 3} → error.
- **JAL**: JUMP, src1 = pc, src2 = J_imm.
- **JALR**: JUMP, src2 = I_imm.
- **LUI**: src1 = U_imm, src2 = 0.
- **AUIPC**: src1 = pc, src2 = U_imm.
- **Other opcodes**: error.

Erroneous instructions:
- Still pass through with `out_valid`.
- `gprs_waddr_o` is forced to x0.
- `error_o` is 1.

Load-use hazard:
- Condition: `ex_is_load` = 1, `ex_gprs_waddr` ≠ x0, and `ex_gprs_waddr` matches an rs the opcode actually uses.
- rs2 is used only by OP, STORE and BRANCH.

## Timing
Reset: all outputs are 0, except:
- `rtltype_o` = ARICH;
- `rtlop_o` = ADD;
- `in_ready` follows its equation below.

Latency: 1 cycle from acceptance (`in_valid` & `in_ready` at an edge) to `out_valid`.

Handshake:
- `in_ready` = (¬`out_valid` | `out_ready`) & ¬hazard. It is combinational.
- Outputs are held stable while `out_valid` & ¬`out_ready`.

Hazard:
- The input is not accepted.
- If EX takes the current output in that cycle, a bubble is loaded: `out_valid` = 0 and waddr = x0.
- The stall persists until the EX destination changes.

Flush:
- `flush_i` at an edge forces `out_valid` to 0 next cycle and drops any concurrent acceptance.
- Flush has priority over accept and hazard.

Reset asserted mid-stall or mid-hold: state clears immediately and no stale output appears after release.

Forwarding is evaluated in the acceptance cycle only. Held outputs are not re-forwarded.

## Configuration
- `ID_MEM_FWD_EN` defined: MEM forwarding is active as described.
- `ID_MEM_FWD_EN` undefined:
  - `mem_gprs_*` are ignored;
  - only EX forwarding applies;
  - a MEM-stage match falls back to register-file data, so the pipeline must write back before it reads.

## Test plan
- `addi x1,x0,5` (0x00500093), pc 0x100 → next cycle: `out_valid` = 1, src1 = 0, src2 = 5, waddr = 1, op = ADD, `error_o` = 0.
- `sub x3,x1,x2` with rs1 = 7, rs2 = 2, `ex_gprs_waddr` = 2, `ex_gprs_wdata` = 9 → src1 = 7, src2 = 0xFFFFFFF7.
- `lw x5` in EX (`ex_is_load` = 1, waddr = 5), ID holds `add x6,x5,x1` → `in_ready` = 0, a bubble is emitted, and the instruction is accepted once `ex_is_load` drops.
- `out_ready` = 0 for 3 cycles with `out_valid` = 1 → outputs unchanged and `in_ready` = 0. Then `out_ready` = 1 → the next instruction appears one cycle later.
- `beq x1,x2,-8` at pc 0x200 → BRANCH, `target_o` = 0x1F8, waddr = 0. Instruction word 0xFFFFFFFF → `error_o` = 1, waddr = 0.
- `flush_i` with `in_valid` = 1 and `out_valid` = 1 → `out_valid` = 0 next cycle. Repeat with `ID_MEM_FWD_EN` undefined: a MEM match on rs1 yields register-file data.
